// File: rtl/mod_initiator.sv
// mod_initiator: requesting side of the addr/req/rdy/data/newaddr read interface.
// Takes a 2-bit command on a valid/ready port, holds req high with a stable addr
// until the responder answers with rdy, and retries a bounded number of times
// after each per-attempt timeout. Each result, success or error, is returned on
// a valid/ready response port.
module mod_initiator #(
  parameter int ADDR  = 22,
  parameter int DATA  = 5,
  parameter int WAIT  = 10,
  parameter int RETRY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_addr,
  output logic [1:0]            addr,
  output logic                  req,
  input  logic                  rdy,
  input  logic [DATA-1:0]       data,
  input  logic [ADDR-4:0]       newaddr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA-1:0]       rsp_data,
  output logic [ADDR-4:0]       rsp_addr,
  output logic                  rsp_err,
  output logic [((RETRY > 0) ? $clog2(RETRY + 1) : 1)-1:0] rsp_retries,
  output logic                  busy
);

  localparam int TW = $clog2(WAIT + 1);
  localparam int RW = (RETRY > 0) ? $clog2(RETRY + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BACKOFF,
    ST_RESP
  } state_t;

  state_t         state;
  logic [TW-1:0]  timer;    // req-high cycles already completed in this attempt
  logic [RW-1:0]  retries;  // retries consumed so far
  logic           last_cycle;
  logic           can_retry;

  // The current WAIT cycle is req-high cycle number timer+1; the attempt ends
  // when that number reaches WAIT.
  assign last_cycle = (timer == TW'(WAIT - 1));
  assign can_retry  = (retries < RW'(RETRY));

  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign busy      = (state != ST_IDLE);

  // Request/response sequencer: accept, hold req, time out and retry, report.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr        <= '0;
      req         <= 1'b0;
      timer       <= '0;
      retries     <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_addr    <= '0;
      rsp_err     <= 1'b0;
      rsp_retries <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr    <= cmd_addr;
            req     <= 1'b1;
            timer   <= '0;
            retries <= '0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rdy) begin
            // A response on the timeout cycle still counts as a success.
            rsp_data    <= data;
            rsp_addr    <= newaddr;
            rsp_err     <= 1'b0;
            rsp_retries <= retries;
            rsp_valid   <= 1'b1;
            req         <= 1'b0;
            state       <= ST_RESP;
          end else if (last_cycle) begin
            req <= 1'b0;
            if (can_retry) begin
              retries <= retries + 1'b1;
              state   <= ST_BACKOFF;
            end else begin
              rsp_data    <= '0;
              rsp_addr    <= '0;
              rsp_err     <= 1'b1;
              rsp_retries <= RW'(RETRY);
              rsp_valid   <= 1'b1;
              state       <= ST_RESP;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_BACKOFF: begin
          // One idle cycle with req low, then a fresh attempt at the same addr.
          req   <= 1'b1;
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_initiator.sv
// tb_mod_initiator: directed and randomized transactions against a cycle-level
// model of the request schedule (attempt windows of WAIT req-high cycles
// separated by one backoff cycle).
module tb_mod_initiator;

  localparam int ADDR  = 22;
  localparam int DATA  = 5;
  localparam int WAIT  = 10;
  localparam int RETRY = 2;
  localparam int NA    = ADDR - 3;
  localparam int RW    = (RETRY > 0) ? $clog2(RETRY + 1) : 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_addr = 2'b00;
  logic [1:0]      addr;
  logic            req;
  logic            rdy = 1'b0;
  logic [DATA-1:0] data = '0;
  logic [NA-1:0]   newaddr = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [DATA-1:0] rsp_data;
  logic [NA-1:0]   rsp_addr;
  logic            rsp_err;
  logic [RW-1:0]   rsp_retries;
  logic            busy;

  int checks = 0;
  int errors = 0;

  mod_initiator #(.ADDR(ADDR), .DATA(DATA), .WAIT(WAIT), .RETRY(RETRY)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .addr(addr), .req(req), .rdy(rdy), .data(data), .newaddr(newaddr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err), .rsp_retries(rsp_retries),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction. ra = attempt index that sees rdy (RETRY+1 = never),
  // rc = req-high cycle within that attempt (1..WAIT), hold = cycles of
  // response backpressure with a competing command held on the cmd port.
  task automatic run_txn(input logic [1:0] a, input int ra, input int rc,
                         input logic [DATA-1:0] d, input logic [NA-1:0] na,
                         input int hold);
    int period;
    bit err;
    int hit;
    int lat;
    logic [DATA-1:0] ed;
    logic [NA-1:0]   ea;
    int              eret;
    period = WAIT + 1;
    err    = (ra > RETRY);
    hit    = ra * period + rc;
    lat    = err ? (RETRY + 1) * period : hit + 1;
    ed     = err ? '0 : d;
    ea     = err ? '0 : na;
    eret   = err ? RETRY : ra;

    cmd_valid = 1'b1;
    cmd_addr  = a;
    chk("cmd_ready_idle", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    cmd_addr  = 2'($urandom);
    for (int n = 1; n < lat; n++) begin
      chk("req_window", req, ((n - 1) % period) != WAIT);
      chk("addr_held", addr, a);
      chk("busy", busy, 1);
      chk("rsp_valid_early", rsp_valid, 0);
      chk("cmd_ready_busy", cmd_ready, 0);
      data    = DATA'($urandom);
      newaddr = NA'($urandom);
      if (!err && n == hit) begin
        rdy     = 1'b1;
        data    = d;
        newaddr = na;
      end else if (((n - 1) % period) == WAIT) begin
        rdy = 1'($urandom_range(0, 1));
      end else begin
        rdy = 1'b0;
      end
      step();
    end
    rdy = 1'b0;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, err);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_addr", rsp_addr, ea);
    chk("rsp_retries", rsp_retries, eret);
    chk("req_low_resp", req, 0);
    chk("cmd_ready_resp", cmd_ready, 0);

    cmd_valid = (hold > 0);
    cmd_addr  = ~a;
    for (int h = 0; h < hold; h++) begin
      rdy     = 1'($urandom_range(0, 1));
      data    = DATA'($urandom);
      newaddr = NA'($urandom);
      step();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, ed);
      chk("hold_addr", rsp_addr, ea);
      chk("hold_err", rsp_err, err);
      chk("hold_req", req, 0);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    rdy       = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("post_hs_valid", rsp_valid, 0);
    chk("post_hs_busy", busy, 0);
    chk("post_hs_req", req, 0);
    chk("post_hs_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Reset state while rst is held.
    rst = 1'b1;
    step();
    step();
    chk("rst_addr", addr, 0);
    chk("rst_req", req, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_retries", rsp_retries, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("cmd_ready_after_rst", cmd_ready, 1);

    // Success on the 3rd req-high cycle of the first attempt.
    run_txn(2'b10, 0, 3, 5'h1A, 19'h51234, 0);
    // Every attempt times out.
    run_txn(2'b01, RETRY + 1, 1, 5'h0F, 19'h7FFFF, 0);
    // Retry, then success on cycle 4 of attempt 2.
    run_txn(2'b11, 1, 4, 5'h07, 19'h00ABC, 1);
    // rdy coincides with the final timeout cycle.
    run_txn(2'b00, RETRY, WAIT, 5'h15, 19'h2468A, 0);
    // Backpressure with a competing command held.
    run_txn(2'b10, 0, 1, 5'h1F, 19'h13579, 5);
    run_txn(2'b01, 0, 2, 5'h03, 19'h0F0F0, 0);

    // Reset in the middle of an attempt.
    cmd_valid = 1'b1;
    cmd_addr  = 2'b11;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mid_req", req, 1);
      rdy = 1'b0;
      if (i == 3) rst = 1'b1;
      step();
    end
    chk("mid_rst_req", req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_cmd_ready_rel", cmd_ready, 1);
    for (int i = 0; i < 6; i++) begin
      rdy     = 1'($urandom_range(0, 1));
      data    = DATA'($urandom);
      newaddr = NA'($urandom);
      step();
      chk("ignored_rdy_valid", rsp_valid, 0);
      chk("ignored_rdy_req", req, 0);
      chk("ignored_rdy_busy", busy, 0);
    end
    rdy = 1'b0;

    // Randomized transactions.
    for (int t = 0; t < 25; t++) begin
      run_txn(2'($urandom), $urandom_range(0, RETRY + 1), $urandom_range(1, WAIT),
              DATA'($urandom), NA'($urandom), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
